// File: rtl/mouse_ps2_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : mouse_ps2_tracker
//  Brief    : PS/2 mouse receiver. Decodes 3-byte movement packets and keeps
//             a clamped absolute pointer position plus left-button state.
//  Revision : 1.0 - initial release
// ============================================================================
module mouse_ps2_tracker #(
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 5000
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        ps2_clock,
    input  logic        ps2_data,
    output logic [15:0] mouse_x,
    output logic [15:0] mouse_y,
    output logic        mouse_pressed_,
    output logic        packet_valid,
    output logic        error
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic signed [17:0] X_MAX_S  = 18'(X_MAX);
    localparam logic signed [17:0] Y_MAX_S  = 18'(Y_MAX);
    localparam logic [15:0]        X_MAX_U  = 16'(X_MAX);
    localparam logic [15:0]        Y_MAX_U  = 16'(Y_MAX);
    localparam logic [15:0]        X_INIT_U = 16'(X_INIT);
    localparam logic [15:0]        Y_INIT_U = 16'(Y_INIT);

    // synchronizers, edge detection
    logic       clk_s1, clk_s2, clk_prev;
    logic       dat_s1, dat_s2;
    logic       sample;
    logic       sample_data;

    // frame receiver
    logic [1:0] state, next_state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       par_bit;
    logic       start_en, shift_en, par_en, stop_en;
    logic       byte_good;

    // packet assembly
    logic [1:0] idx;
    logic       b0_left, b0_xs, b0_ys, b0_xo, b0_yo;
    logic [7:0] b1;

    // watchdog
    logic [WD_W-1:0] wd;
    logic            busy;
    logic            timeout;

    // position arithmetic
    logic signed [17:0] dx_ext, dy_ext, x_sum, y_sum;
    logic [15:0]        x_clamp, y_clamp;

    // Two-flop synchronizers (idle bus = 1) and a registered falling-edge strobe;
    // the data bit is registered alongside so it lines up with the strobe.
    always_ff @(posedge clock) begin
        if (reset_) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_prev    <= 1'b1;
            dat_s1      <= 1'b1;
            dat_s2      <= 1'b1;
            sample      <= 1'b0;
            sample_data <= 1'b1;
        end else begin
            clk_s1      <= ps2_clock;
            clk_s2      <= clk_s1;
            clk_prev    <= clk_s2;
            dat_s1      <= ps2_data;
            dat_s2      <= dat_s1;
            sample      <= clk_prev & ~clk_s2;
            sample_data <= dat_s2;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clock) begin
        if (reset_) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Frame FSM next-state logic; a watchdog expiry forces the FSM back to IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (sample && !sample_data)     next_state = ST_DATA;
            ST_DATA:   if (sample && bit_cnt == 3'd7)  next_state = ST_PARITY;
            ST_PARITY: if (sample)                     next_state = ST_STOP;
            ST_STOP:   if (sample)                     next_state = ST_IDLE;
            default:                                   next_state = ST_IDLE;
        endcase
        if (timeout) next_state = ST_IDLE;
    end

    // Frame FSM outputs: per-state strobes that steer the datapath
    always_comb begin
        start_en = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        case (state)
            ST_IDLE:   start_en = sample && !sample_data;
            ST_DATA:   shift_en = sample;
            ST_PARITY: par_en   = sample;
            ST_STOP:   stop_en  = sample;
            default:   ;
        endcase
    end

    // Odd parity over data + parity bit, and the stop bit must be high
    assign byte_good = sample_data & (^{shift, par_bit});

    // Bit collection: LSB-first shift register, bit counter, parity capture
    always_ff @(posedge clock) begin
        if (reset_) begin
            bit_cnt <= 3'd0;
            shift   <= 8'd0;
            par_bit <= 1'b0;
        end else begin
            if (start_en) bit_cnt <= 3'd0;
            if (shift_en) begin
                shift   <= {sample_data, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (par_en) par_bit <= sample_data;
        end
    end

    // Watchdog: runs only while a frame or packet is in progress; any sample
    // clears it, so a sample coinciding with expiry takes precedence
    assign busy    = (state != ST_IDLE) || (idx != 2'd0);
    assign timeout = busy && !sample && (wd == WD_LAST);

    // Watchdog counter
    always_ff @(posedge clock) begin
        if (reset_)                        wd <= '0;
        else if (sample || timeout || !busy) wd <= '0;
        else                               wd <= wd + 1'b1;
    end

    // Deltas are 9-bit two's complement; an overflowed axis contributes zero.
    // Y is negated because PS/2 reports up as positive but the screen grows down.
    always_comb begin
        dx_ext  = b0_xo ? 18'sd0 : {{9{b0_xs}}, b0_xs, b1};
        dy_ext  = b0_yo ? 18'sd0 : {{9{b0_ys}}, b0_ys, shift};
        x_sum   = $signed({2'b00, mouse_x}) + dx_ext;
        y_sum   = $signed({2'b00, mouse_y}) - dy_ext;
        x_clamp = x_sum[15:0];
        y_clamp = y_sum[15:0];
        if (x_sum[17])           x_clamp = 16'd0;
        else if (x_sum > X_MAX_S) x_clamp = X_MAX_U;
        if (y_sum[17])           y_clamp = 16'd0;
        else if (y_sum > Y_MAX_S) y_clamp = Y_MAX_U;
    end

    // Packet assembly, position update and status pulses
    always_ff @(posedge clock) begin
        if (reset_) begin
            idx            <= 2'd0;
            b0_left        <= 1'b0;
            b0_xs          <= 1'b0;
            b0_ys          <= 1'b0;
            b0_xo          <= 1'b0;
            b0_yo          <= 1'b0;
            b1             <= 8'd0;
            mouse_x        <= X_INIT_U;
            mouse_y        <= Y_INIT_U;
            mouse_pressed_ <= 1'b0;
            packet_valid   <= 1'b0;
            error          <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            error        <= 1'b0;
            if (timeout) begin
                idx   <= 2'd0;
                error <= 1'b1;
            end else if (stop_en) begin
                if (!byte_good) begin
                    idx   <= 2'd0;
                    error <= 1'b1;
                end else begin
                    case (idx)
                        2'd0: begin
                            // bit3 is always set in a header byte; use it to resync
                            if (shift[3]) begin
                                b0_left <= shift[0];
                                b0_xs   <= shift[4];
                                b0_ys   <= shift[5];
                                b0_xo   <= shift[6];
                                b0_yo   <= shift[7];
                                idx     <= 2'd1;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                        2'd1: begin
                            b1  <= shift;
                            idx <= 2'd2;
                        end
                        default: begin
                            mouse_x        <= x_clamp;
                            mouse_y        <= y_clamp;
                            mouse_pressed_ <= b0_left;
                            packet_valid   <= 1'b1;
                            idx            <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mouse_ps2_tracker.md
# mouse_ps2_tracker

Upstream input stage for the mouse-driven counter logic: receives the PS/2 mouse serial stream, decodes standard 3-byte movement packets and maintains a clamped absolute pointer position plus left-button state. Its `mouse_x` and `mouse_pressed_` outputs drive the counter stage directly; `mouse_y` and the status pulses feed display and debug logic.

## Interface

- `X_MAX`, 639: upper clamp for `mouse_x` (lower clamp is 0)
- `Y_MAX`, 479: upper clamp for `mouse_y` (lower clamp is 0)
- `X_INIT`, 320: reset value of `mouse_x`
- `Y_INIT`, 240: reset value of `mouse_y`
- `TIMEOUT`, 5000: `clock` cycles without a PS/2 falling edge before a partial frame/packet is abandoned

- `clock` in 1: single system clock; all logic on posedge
- `reset_` in 1: synchronous, active-high reset
- `ps2_clock` in 1: PS/2 clock line, asynchronous to `clock`
- `ps2_data` in 1: PS/2 data line, asynchronous to `clock`
- `mouse_x` out 16: absolute X, unsigned, 0..X_MAX
- `mouse_y` out 16: absolute Y, unsigned, 0..Y_MAX, screen orientation (down = increasing)
- `mouse_pressed_` out 1: 1 while left button held (latest accepted packet)
- `packet_valid` out 1: one-cycle pulse when a packet is accepted
- `error` out 1: one-cycle pulse on any framing/sync/timeout error

## Operation

- Both PS/2 lines pass through 2-flop synchronizers; falling-edge detect on synced clock (previous 1, current 0) yields `sample`.
- Frame FSM, states IDLE, DATA, PARITY, STOP; each transition only on `sample`:
  - IDLE: data 0 → DATA (bit count 0); data 1 → stay IDLE (no error).
  - DATA: shift data into byte LSB-first; after 8th bit → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: byte good iff stop bit = 1 and odd parity (ones in 8 data bits + parity bit is odd); → IDLE either way.
- Bad byte: `error` pulse, byte discarded, packet index → 0.
- Packet index 0..2:
  - Byte 0 requires bit3 = 1; else `error` pulse, index stays 0 (resync).
  - Byte 0 fields: bit0 left, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - Byte 1 = X delta low 8, byte 2 = Y delta low 8; deltas are 9-bit two's complement {sign, byte}.
- On byte 2 accept:
  - Axis with overflow set uses delta 0.
  - x_next = mouse_x + dx, y_next = mouse_y − dy, computed signed ≥18 bits.
  - Clamp each to [0, MAX].
  - `mouse_pressed_` ← byte0 bit0, `packet_valid` pulses, index → 0.
- Watchdog: counter clears on every `sample`; counts while FSM ≠ IDLE or index ≠ 0. Reaching TIMEOUT → FSM IDLE, index 0, `error` pulse, counter cleared. Outputs unchanged.
- Position/button never change except on an accepted packet or reset.

## Timing

- Reset (any cycle, overrides all): `mouse_x`=X_INIT, `mouse_y`=Y_INIT, `mouse_pressed_`=0, `packet_valid`=0, `error`=0; FSM IDLE, index 0, watchdog 0, synchronizers cleared to 1 (idle bus). Partial frame/packet lost.
- `ps2_clock` falling edge to `sample`: 3 cycles (2 sync + edge register).
- Stop bit `sample` in cycle N → updated position/button and `packet_valid` visible in N+1; `error` for a bad stop/parity/sync likewise in N+1.
- `packet_valid` and `error` never assert in the same cycle; each is exactly one cycle wide.
- Timeout and `sample` in the same cycle: `sample` wins, counter clears.
- Boundaries: at 0 with negative delta → stays 0; at MAX with positive delta → stays MAX; delta −256 and +255 handled without wrap.

## Test plan

- Reset, then idle lines for 100 cycles → `mouse_x`=320, `mouse_y`=240, `mouse_pressed_`=0, no `packet_valid`/`error`.
- Packet 0x09, 0x0A, 0x05 → `mouse_x`=330, `mouse_y`=235, `mouse_pressed_`=1, exactly one `packet_valid` one cycle after byte-2 stop sample.
- From reset, packet 0x18, 0x00, 0x00 twice → `mouse_x`=64 then 0 (clamped); packet 0x08, 0xFF, 0x00 repeated three times → 255, 510, 639 (clamped).
- Byte 1 sent with bad parity → `error` pulse, no `packet_valid`, position unchanged; next good packet 0x08, 0x01, 0x00 → `mouse_x`+1.
- Byte 0 = 0x01 (bit3 clear) → `error`, ignored; then 0x08, 0x02, 0x00 accepted as a new packet. Byte 0 alone then idle TIMEOUT+10 cycles → one `error` pulse; following full packet decodes correctly.
- Packet 0x49, 0xFF, 0x00 → X unchanged, `mouse_pressed_`=1, `packet_valid` pulse. `reset_` asserted mid-byte-1 → reset values, subsequent packet decodes from index 0.
